// File: rtl/morse_tx_param.sv
// Parametrised Morse-pattern serialiser: plays an LSB-first on/off pattern at DIV clocks
// per unit, appends a GAP_UNITS-unit low gap, then pulses done; supports repeat and abort.
module morse_tx_param #(
    parameter int SYM_W     = 16,
    parameter int LEN_W     = 5,
    parameter int DIV       = 25000000,
    parameter int GAP_UNITS = 3
) (
    input  logic             clk,
    input  logic             asr_n,
    input  logic [SYM_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic             start,
    input  logic             rpt,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             out,
    output logic             done
);

    localparam int DIV_W    = $clog2(DIV + 1);
    localparam int GAP_W    = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
    localparam int GAP_LAST = (GAP_UNITS > 0) ? GAP_UNITS - 1 : 0;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SYM_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   pat_q, pat_d;
    logic [SYM_W-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               out_q, out_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   eff_len;
    logic               load;
    logic               eol;
    logic [SYM_W-1:0]   load_pat;
    logic [LEN_W-1:0]   load_len;

    always_comb begin
        eff_len = (len > LEN_MAX) ? LEN_MAX : len;
    end

    // The end-of-letter decision is made in the last gap cycle, so done and the next
    // letter's first bit (repeat) or ready (no repeat) appear on the same edge.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = out_q;
        done_d    = 1'b0;
        load      = 1'b0;
        eol       = 1'b0;
        load_pat  = pat_q;
        load_len  = len_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load     = 1'b1;
                    load_pat = pat;
                    load_len = eff_len;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end else if (div_cnt_q == '0) begin
                    div_cnt_d = DIV_LAST;
                    if (bit_cnt_q == len_q - 1'b1) begin
                        if (GAP_UNITS == 0) begin
                            eol = 1'b1;
                        end else begin
                            state_d   = GAP;
                            out_d     = 1'b0;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                        out_d     = shreg_q[1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end else if (div_cnt_q == '0) begin
                    div_cnt_d = DIV_LAST;
                    if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                        eol = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
            end
        endcase

        if (eol) begin
            done_d = 1'b1;
            if (rpt) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
                out_d   = 1'b0;
            end
        end

        // A zero-length letter skips SEND and goes straight to the gap.
        if (load) begin
            pat_d     = load_pat;
            len_d     = load_len;
            shreg_d   = load_pat;
            bit_cnt_d = '0;
            div_cnt_d = DIV_LAST;
            gap_cnt_d = '0;
            if (load_len == '0) begin
                out_d = 1'b0;
                if (GAP_UNITS == 0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end else begin
                state_d = SEND;
                out_d   = load_pat[0];
            end
        end
    end

    always_ff @(posedge clk or negedge asr_n) begin
        if (!asr_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            done_q    <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_morse_tx_param.sv
// Bench for morse_tx_param (DIV=4, GAP_UNITS=3): directed and random letters checked
// cycle by cycle against a waveform computed from pattern, length and repeat count.
module tb_morse_tx_param;

    localparam int SYM_W = 16;
    localparam int LEN_W = 5;
    localparam int DIV   = 4;
    localparam int GAPU  = 3;

    logic             clk = 1'b0;
    logic             asr_n = 1'b0;
    logic [SYM_W-1:0] pat = '0;
    logic [LEN_W-1:0] len = '0;
    logic             start = 1'b0;
    logic             rpt = 1'b0;
    logic             abort = 1'b0;
    logic             ready, busy, out, done;

    int checks = 0;
    int failures = 0;
    int cur_k = 0;

    morse_tx_param #(.SYM_W(SYM_W), .LEN_W(LEN_W), .DIV(DIV), .GAP_UNITS(GAPU)) dut (
        .clk(clk), .asr_n(asr_n), .pat(pat), .len(len), .start(start), .rpt(rpt),
        .abort(abort), .ready(ready), .busy(busy), .out(out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_out"},   32'(out),   32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
    endtask

    // Reference: letter of eff bits + GAPU units, repeated nlet times back to back.
    // Cycle k counts from the first out cycle; done shows at each multiple of the period.
    task automatic run_letter(input logic [SYM_W-1:0] p, input logic [LEN_W-1:0] l,
                              input int nlet, input bit disturb);
        int eff, per, total;
        logic e_out;
        eff   = (int'(l) > SYM_W) ? SYM_W : int'(l);
        per   = (eff + GAPU) * DIV;
        total = nlet * per;
        pat   = p;
        len   = l;
        rpt   = (nlet > 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= total + 1; k++) begin
            cur_k = k;
            e_out = (k < total && (k % per) < eff * DIV) ? p[(k % per) / DIV] : 1'b0;
            check("out",   32'(out),   32'(e_out));
            check("done",  32'(done),  32'(k > 0 && k <= total && (k % per) == 0));
            check("busy",  32'(busy),  32'(k < total));
            check("ready", 32'(ready), 32'(k >= total));
            if (k == (nlet - 1) * per) rpt = 1'b0;
            if (disturb && k <= total - 2) begin
                start = 1'b1;
                pat   = 16'($urandom());
                len   = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic abort_letter(input logic [SYM_W-1:0] p, input logic [LEN_W-1:0] l,
                                input int ak);
        int eff;
        logic e_out;
        eff   = (int'(l) > SYM_W) ? SYM_W : int'(l);
        pat   = p;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= ak; k++) begin
            cur_k = k;
            e_out = (k < eff * DIV) ? p[k / DIV] : 1'b0;
            check("ab_out",  32'(out),  32'(e_out));
            check("ab_busy", 32'(busy), 32'd1);
            if (k == ak) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        cur_k = ak + 1;
        check_idle("after_abort");
        for (int k = 0; k < (eff + GAPU) * DIV; k++) begin
            cur_k = ak + 2 + k;
            tick();
            check("no_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_idle("reset");
        asr_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Asynchronous reset in the middle of SEND
        pat   = 16'hFFFF;
        len   = 5'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_out", 32'(out), 32'd1);
        #2 asr_n = 1'b0;
        #1;
        check_idle("mid_rst");
        #2 asr_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            check("rst_no_done", 32'(done), 32'd0);
        end

        // Directed letters
        run_letter(16'b10111, 5'd5, 1, 1'b0);
        run_letter(16'hA5C3, 5'd0, 1, 1'b0);
        run_letter(16'hB38D, 5'd31, 1, 1'b0);
        run_letter(16'b10111, 5'd5, 1, 1'b1);
        run_letter(16'b101, 5'd3, 3, 1'b0);

        // Abort at the sixth SEND cycle, then abort together with start in IDLE
        abort_letter(16'b1101, 5'd4, 5);
        pat   = 16'hFFFF;
        len   = 5'd8;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_start");
        tick();
        check_idle("abort_start2");

        // Random letters, repeats, disturbances and aborts
        for (int i = 0; i < 8; i++) begin
            run_letter(16'($urandom()), 5'($urandom_range(0, 31)),
                       $urandom_range(1, 2), 1'($urandom()));
        end
        for (int i = 0; i < 3; i++) begin
            abort_letter(16'($urandom()), 5'($urandom_range(1, 16)), $urandom_range(0, 15));
        end
        abort_letter(16'h00FF, 5'd2, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
